serial_tx_framer: RTL and testbench
===================================

# serial_tx_framer

Serial transmit framer for the Lab4 serial link. It accepts one parallel byte per load pulse and drives it onto a single-wire line as an asynchronous frame: one start bit (0), DATA_BITS data bits LSB first, then one stop bit (1). Every bit is held for OVERSAMPLE clock cycles. This matches the 16-phase bit period the receive-side sampling counter expects, so the receiver samples each bit at its centre.

## Interface
Parameters:
- DATA_BITS, default 8: data bits per frame. Legal range 1..16.
- OVERSAMPLE, default 16: clk cycles per bit. Legal range 2..256.

Ports:
- clk, input, 1: system clock. All state changes on its rising edge.
- reset, input, 1: asynchronous, active-low reset (0 = reset).
- load, input, 1: request to send. Sampled on each rising edge of clk.
- data_in, input, DATA_BITS: byte to send. Captured on the edge that accepts load.
- tx_out, output, 1: serial line. Idle level is 1.
- busy, output, 1: high while a frame is in progress.
- done, output, 1: one-cycle pulse when the stop bit completes.

## Operation
- FSM states and registered outputs:
  - IDLE: tx_out=1, busy=0.
  - START: tx_out=0.
  - DATA: tx_out=shift_reg[0].
  - STOP: tx_out=1.
  - busy=1 in START, DATA and STOP.
- Counters:
  - Phase counter ph, width ceil(log2(OVERSAMPLE)). Counts 0..OVERSAMPLE-1 in every non-IDLE state. It is cleared on entry to each state and whenever the data bit index advances.
  - Bit index bi, 0..DATA_BITS-1, used in DATA only.
- IDLE -> START: load=1 at an edge while the state is IDLE.
  - shift_reg <= data_in, ph <= 0.
  - tx_out <= 0 and busy <= 1 on the same edge.
- START -> DATA: at the edge where ph==OVERSAMPLE-1.
  - tx_out <= shift_reg[0], bi <= 0.
- Within DATA, at each edge where ph==OVERSAMPLE-1:
  - If bi<DATA_BITS-1: shift_reg shifts right by one, bi increments, tx_out <= next bit.
  - If bi==DATA_BITS-1: go to STOP, tx_out <= 1.
- STOP -> IDLE: at the edge where ph==OVERSAMPLE-1.
  - busy <= 0 and done <= 1 for exactly one cycle.
- load outside IDLE is ignored and is not queued. data_in is don't-care except on the accepting edge.
- Changing data_in mid-frame must not alter the frame, because the data was captured at acceptance.
- Reset:
  - reset=0 asynchronously forces state IDLE, tx_out=1, busy=0, done=0, ph=0, bi=0, shift_reg=0.
  - Applies mid-frame too. The frame is abandoned, the line returns to idle-high immediately, and no done pulse is produced.
  - On release, the first load is honoured at the first edge where reset=1.

## Timing
- Let E0 be the edge that accepts load.
- Start bit: tx_out=0 for cycles E0..E0+OVERSAMPLE-1.
- Data bit k (0-based): driven from edge E0+OVERSAMPLE*(k+1) for OVERSAMPLE cycles.
- Stop bit: begins at E0+OVERSAMPLE*(DATA_BITS+1) and ends at E0+OVERSAMPLE*(DATA_BITS+2).
- End-of-frame edge F = E0+OVERSAMPLE*(DATA_BITS+2):
  - busy falls, done=1.
  - done returns to 0 at F+1.
- At F the state is still STOP, so a load at F is ignored. The earliest back-to-back acceptance is F+1, giving a minimum frame spacing of OVERSAMPLE*(DATA_BITS+2)+1 cycles (161 at defaults).
- Defaults: a frame occupies 160 cycles of line time.
- All outputs are registered, with no combinational path from any input to any output.

## Test plan
- Reset behaviour: hold reset=0 for 3 cycles, then release. Required:
  - tx_out=1, busy=0, done=0 throughout.
  - No activity for 50 idle cycles.
- Single frame with defaults: load with data_in=0xA5 at E0. Required:
  - Sampling tx_out at E0+8+16n for n=0..9 yields 0, 1,0,1,0,0,1,0,1, 1.
  - busy=1 from E0 to E0+159. done=1 only in cycle E0+160.
- Ignored load: start 0x00, then pulse load with data_in=0xFF at E0+40. Required:
  - Frame is still 0x00: all data samples 0.
  - Only one done pulse.
  - tx_out=1 after E0+160.
- Back-to-back: load 0x3C at E0 and hold load=1 with data_in=0xC3. Required:
  - load is ignored at E0+160.
  - Second start bit begins at E0+161.
  - Second frame decodes to 0xC3.
- Mid-frame reset: start 0x55, assert reset=0 asynchronously at E0+70 (between edges). Required:
  - tx_out=1 and busy=0 immediately, without waiting for a clock edge.
  - No done pulse.
  - After release, a new load of 0x81 transmits correctly.
- Parameter sweep: DATA_BITS=5, OVERSAMPLE=4, data 0x13. Required:
  - Bit samples 0,1,1,0,0,1,1.
  - done at E0+28.

Source files
------------

// File: rtl/serial_tx_framer.sv
// Serial transmit framer: one start bit, DATA_BITS data bits LSB first, one stop bit,
// each bit held for OVERSAMPLE clock cycles. All outputs are registered.
module serial_tx_framer #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 tx_out,
    output logic                 busy,
    output logic                 done
);

    localparam int PH_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BI_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);
    localparam logic [BI_W-1:0] BI_LAST = BI_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [PH_W-1:0]      ph;
    logic [PH_W-1:0]      ph_next;
    logic [BI_W-1:0]      bi;
    logic [BI_W-1:0]      bi_next;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] shift_next;
    logic [DATA_BITS-1:0] shift_down;
    logic                 tx_next;
    logic                 busy_next;
    logic                 done_next;
    logic                 ph_wrap;

    assign ph_wrap    = (ph == PH_LAST);
    assign shift_down = shift_reg >> 1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ph        <= '0;
            bi        <= '0;
            shift_reg <= '0;
            tx_out    <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            ph        <= ph_next;
            bi        <= bi_next;
            shift_reg <= shift_next;
            tx_out    <= tx_next;
            busy      <= busy_next;
            done      <= done_next;
        end
    end

    // Outputs are computed one cycle ahead so the line changes on the same edge as the state.
    always_comb begin
        state_next = state;
        ph_next    = ph_wrap ? '0 : ph + PH_W'(1);
        bi_next    = bi;
        shift_next = shift_reg;
        tx_next    = tx_out;
        busy_next  = busy;
        done_next  = 1'b0;

        case (state)
            IDLE: begin
                ph_next   = '0;
                bi_next   = '0;
                tx_next   = 1'b1;
                busy_next = 1'b0;
                if (load) begin
                    state_next = START;
                    shift_next = data_in;
                    tx_next    = 1'b0;
                    busy_next  = 1'b1;
                end
            end
            START: begin
                if (ph_wrap) begin
                    state_next = DATA;
                    tx_next    = shift_reg[0];
                    bi_next    = '0;
                end
            end
            DATA: begin
                if (ph_wrap) begin
                    if (bi != BI_LAST) begin
                        shift_next = shift_down;
                        bi_next    = bi + BI_W'(1);
                        tx_next    = shift_down[0];
                    end else begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end
                end
            end
            STOP: begin
                if (ph_wrap) begin
                    state_next = IDLE;
                    tx_next    = 1'b1;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                ph_next    = '0;
                tx_next    = 1'b1;
                busy_next  = 1'b0;
            end
        endcase
    end

    // The line may only be low inside a frame, and done marks the return to idle.
    a_low_only_when_busy : assert property (@(posedge clk) disable iff (!reset) !tx_out |-> busy);
    a_done_at_idle       : assert property (@(posedge clk) disable iff (!reset) done |-> (!busy && tx_out));

endmodule

// File: tb/tb_serial_tx_framer.sv
// Self-checking bench for serial_tx_framer: a default-parameter instance checked against a
// timing-arithmetic line model plus directed sequences, and a 5-bit/4x instance checked from a vector table.
module tb_serial_tx_framer;

    localparam int DB_A    = 8;
    localparam int OS_A    = 16;
    localparam int FRAME_A = OS_A * (DB_A + 2);
    localparam int HIST    = 512;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load_a = 1'b0;
    logic [7:0] data_a = 8'h00;
    logic       tx_a, busy_a, done_a;
    logic       load_b = 1'b0;
    logic [4:0] data_b = 5'h00;
    logic       tx_b, busy_b, done_b;

    int n_checks = 0;
    int n_fail   = 0;

    serial_tx_framer dut_a (
        .clk(clk), .reset(reset), .load(load_a), .data_in(data_a),
        .tx_out(tx_a), .busy(busy_a), .done(done_a)
    );

    serial_tx_framer #(.DATA_BITS(5), .OVERSAMPLE(4)) dut_b (
        .clk(clk), .reset(reset), .load(load_b), .data_in(data_b),
        .tx_out(tx_b), .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the line is a pure function of the time elapsed since the accepting edge.
    longint     cyc = 0;
    longint     e0 = 0;
    logic [7:0] mdata = 8'h00;
    bit         have = 1'b0;
    logic [2:0] exp_line;

    function automatic logic [2:0] line_model(input logic [7:0] d, input longint t);
        int bitno;
        if (t < 0 || t > FRAME_A) return 3'b100;
        if (t == FRAME_A) return 3'b101;
        bitno = int'(t / OS_A);
        if (bitno == 0) return 3'b010;
        if (bitno <= DB_A) return {d[bitno-1], 2'b10};
        return 3'b110;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            have = 1'b0;
        end else begin
            cyc++;
            if (load_a && (!have || (cyc - e0) > FRAME_A)) begin
                have  = 1'b1;
                e0    = cyc;
                mdata = data_a;
            end
        end
    end

    always @(negedge clk) begin
        exp_line = (have && reset) ? line_model(mdata, cyc - e0) : 3'b100;
        check_output("line_a", {tx_a, busy_a, done_a}, exp_line);
    end

    // Directed-sequence helpers: tcur is the cycle offset from the accepting edge of DUT A.
    int   tcur = 0;
    int   done_seen = 0;
    logic hist [0:HIST-1];

    task automatic step();
        @(negedge clk);
        tcur++;
        if (tcur >= 0 && tcur < HIST) hist[tcur] = tx_a;
        if (done_a) done_seen++;
    endtask

    task automatic run_to(input int t);
        while (tcur < t) step();
    endtask

    task automatic apply_stimulus(input logic [7:0] d, input bit hold);
        @(negedge clk);
        load_a = 1'b1;
        data_a = d;
        tcur   = -1;
        step();
        if (!hold) load_a = 1'b0;
    endtask

    function automatic logic [7:0] decode_hist(input int base);
        logic [7:0] d;
        for (int k = 0; k < DB_A; k++) d[k] = hist[base + OS_A/2 + OS_A*(k+1)];
        return d;
    endfunction

    task automatic check_frame(input string name, input int base, input logic [7:0] d);
        check_output({name, "_start"}, 32'(hist[base + OS_A/2]), 32'd0);
        check_output({name, "_data"}, 32'(decode_hist(base)), 32'(d));
        check_output({name, "_stop"}, 32'(hist[base + OS_A/2 + OS_A*(DB_A+1)]), 32'd1);
    endtask

    typedef struct {
        logic       load;
        logic [4:0] data;
        logic       tx;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t tbl [30];

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        logic [6:0] samp_b;
        logic [7:0] rd;
        bit         all_high;

        // Reset held for three cycles, then fifty quiet idle cycles.
        repeat (3) begin
            @(negedge clk);
            check_output("reset_hold", {tx_a, busy_a, done_a, tx_b, busy_b, done_b}, 32'b100100);
        end
        reset = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check_output("idle", {tx_a, busy_a, done_a, tx_b, busy_b, done_b}, 32'b100100);
        end

        // Single 0xA5 frame.
        done_seen = 0;
        apply_stimulus(8'hA5, 1'b0);
        check_output("a5_busy_e0", 32'(busy_a), 32'd1);
        run_to(159);
        check_output("a5_busy_159", 32'({busy_a, done_a}), 32'b10);
        run_to(160);
        check_output("a5_end", 32'({tx_a, busy_a, done_a}), 32'b101);
        run_to(161);
        check_output("a5_done_drop", 32'(done_a), 32'd0);
        check_frame("a5", 0, 8'hA5);
        check_output("a5_done_count", 32'(done_seen), 32'd1);

        // Load while busy is ignored, and data_in changes do not leak in.
        done_seen = 0;
        apply_stimulus(8'h00, 1'b0);
        run_to(40);
        load_a = 1'b1;
        data_a = 8'hFF;
        step();
        load_a = 1'b0;
        run_to(200);
        check_frame("ign", 0, 8'h00);
        check_output("ign_done_count", 32'(done_seen), 32'd1);
        all_high = 1'b1;
        for (int t = 161; t <= 200; t++) if (hist[t] !== 1'b1) all_high = 1'b0;
        check_output("ign_idle_after", 32'(all_high), 32'd1);

        // Back-to-back with load held high: acceptance at F+1, not F.
        done_seen = 0;
        apply_stimulus(8'h3C, 1'b1);
        data_a = 8'hC3;
        run_to(160);
        check_output("b2b_f", 32'({tx_a, busy_a, done_a}), 32'b101);
        run_to(161);
        check_output("b2b_second_start", 32'({tx_a, busy_a}), 32'b01);
        load_a = 1'b0;
        run_to(161 + FRAME_A + 1);
        check_frame("b2b_first", 0, 8'h3C);
        check_frame("b2b_second", 161, 8'hC3);
        check_output("b2b_done_count", 32'(done_seen), 32'd2);

        // Asynchronous reset mid-frame, then a load on the first edge after release.
        done_seen = 0;
        apply_stimulus(8'h55, 1'b0);
        run_to(70);
        #2;
        reset = 1'b0;
        #1;
        check_output("rst_async", 32'({tx_a, busy_a, done_a}), 32'b100);
        step();
        step();
        reset  = 1'b1;
        load_a = 1'b1;
        data_a = 8'h81;
        tcur   = -1;
        step();
        load_a = 1'b0;
        run_to(160);
        check_output("rst_new_done", 32'(done_a), 32'd1);
        run_to(161);
        check_frame("rst_new", 0, 8'h81);
        check_output("rst_done_count", 32'(done_seen), 32'd1);

        // Random frames with random load noise while busy.
        for (int n = 0; n < 6; n++) begin
            rd = 8'($urandom);
            repeat ($urandom_range(0, 5)) step();
            done_seen = 0;
            apply_stimulus(rd, 1'b0);
            while (tcur < 159) begin
                load_a = ($urandom_range(0, 3) == 0);
                data_a = 8'($urandom);
                step();
            end
            load_a = 1'b0;
            run_to(161);
            check_frame($sformatf("rand%0d", n), 0, rd);
            check_output($sformatf("rand%0d_done_count", n), 32'(done_seen), 32'd1);
        end

        // DATA_BITS=5, OVERSAMPLE=4, data 0x13: bit samples 0,1,1,0,0,1,1 and done at E0+28.
        samp_b = 7'b1100110;
        for (int i = 0; i < 30; i++) begin
            tbl[i].load = (i == 0) || (i == 10) || (i == 28);
            tbl[i].data = (i == 0) ? 5'h13 : 5'(i * 7);
            tbl[i].tx   = (i < 28) ? samp_b[i / 4] : 1'b1;
            tbl[i].busy = (i < 28);
            tbl[i].done = (i == 28);
        end
        @(negedge clk);
        load_b = tbl[0].load;
        data_b = tbl[0].data;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check_output($sformatf("vec_b[%0d]", i), 32'({tx_b, busy_b, done_b}),
                         32'({tbl[i].tx, tbl[i].busy, tbl[i].done}));
            if (i < 29) begin
                load_b = tbl[i+1].load;
                data_b = tbl[i+1].data;
            end
        end
        load_b = 1'b0;
        @(negedge clk);
        check_output("vec_b_idle", 32'({tx_b, busy_b, done_b}), 32'b100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
